// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
//  Module   : clock_divider_multi
//  Brief    : Runtime-programmable multi-channel clock/strobe divider.
//             Each channel produces a divided enable (clock_out) and a
//             period-start pulse (tick_out). Period/high time are written
//             into a shadow register and applied only at a period boundary
//             (or immediately while the channel is disabled), so a running
//             output never sees a truncated or stretched period.
//  Options  : CLKDIV_TICK_EN - when defined, tick_out is generated;
//             otherwise the tick registers are removed and tick_out is 0.
//  Revision : 1.0  initial release
// ============================================================================
module clock_divider_multi #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 28,
  parameter int DEFAULT_DIV  = 15,
  parameter int DEFAULT_HIGH = 1,
  localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_high,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick_out
);

  // Smallest legal period; anything below is stored as this value.
  localparam logic [CNT_W-1:0] c_min_div  = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_def_div  = (DEFAULT_DIV < 2) ? c_min_div : CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] c_def_high = CNT_W'(DEFAULT_HIGH);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < c_min_div) ? c_min_div : d;
  endfunction

  logic w_cfg_fire;

  // A channel can take a new config only once its previous one has been
  // applied; out-of-range channel numbers are always ready and discarded.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CHAN_W'(i)) begin
        cfg_ready = !pending[i];
      end
    end
  end

  assign w_cfg_fire = cfg_valid & cfg_ready;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_a_q, div_a_d;
    logic [CNT_W-1:0] high_a_q, high_a_d;
    logic [CNT_W-1:0] div_s_q, div_s_d;
    logic [CNT_W-1:0] high_s_q, high_s_d;
    logic             pending_q, pending_d;
    logic             clk_q, clk_d;
    logic             w_wrap;
    logic             w_apply;
    logic             w_write;

    assign w_wrap  = (cnt_q == div_a_q - CNT_W'(1));
    assign w_apply = pending_q & (~enable[gi] | w_wrap);
    assign w_write = w_cfg_fire & (cfg_chan == CHAN_W'(gi));

    // Counter, output phase, and shadow-to-active transfer at period end.
    always_comb begin
      cnt_d     = cnt_q;
      div_a_d   = div_a_q;
      high_a_d  = high_a_q;
      div_s_d   = div_s_q;
      high_s_d  = high_s_q;
      pending_d = pending_q;
      clk_d     = 1'b0;
      if (enable[gi]) begin
        clk_d = (cnt_q < high_a_q);
        cnt_d = w_wrap ? '0 : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
      // The output on the apply edge still uses the old high time; the new
      // values govern from the next period start onward.
      if (w_apply) begin
        div_a_d   = div_s_q;
        high_a_d  = high_s_q;
        pending_d = 1'b0;
      end
      // Cannot coincide with apply: a write needs pending clear.
      if (w_write) begin
        div_s_d   = clamp_div(cfg_div);
        high_s_d  = cfg_high;
        pending_d = 1'b1;
      end
    end

    // Channel state registers with synchronous reset to the defaults.
    always_ff @(posedge clock_in) begin
      if (reset) begin
        cnt_q     <= '0;
        div_a_q   <= c_def_div;
        high_a_q  <= c_def_high;
        div_s_q   <= c_def_div;
        high_s_q  <= c_def_high;
        pending_q <= 1'b0;
        clk_q     <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        div_a_q   <= div_a_d;
        high_a_q  <= high_a_d;
        div_s_q   <= div_s_d;
        high_s_q  <= high_s_d;
        pending_q <= pending_d;
        clk_q     <= clk_d;
      end
    end

    assign clock_out[gi] = clk_q;
    assign pending[gi]   = pending_q;

`ifdef CLKDIV_TICK_EN
    logic tick_q, tick_d;

    // Period-start pulse: counter at phase 0 while running.
    always_comb begin
      tick_d = enable[gi] & (cnt_q == '0);
    end

    // Tick register.
    always_ff @(posedge clock_in) begin
      if (reset) begin
        tick_q <= 1'b0;
      end else begin
        tick_q <= tick_d;
      end
    end

    assign tick_out[gi] = tick_q;
`else
    assign tick_out[gi] = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_divider_multi
//  Brief    : Directed self-checking bench for clock_divider_multi with a
//             cycle-level reference model feeding an expected-value queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_divider_multi;

  localparam int CH = 4;
  localparam int W  = 28;

  logic          clock_in = 1'b0;
  logic          reset;
  logic [CH-1:0] enable;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_chan;
  logic [W-1:0]  cfg_div;
  logic [W-1:0]  cfg_high;
  logic [CH-1:0] pending;
  logic [CH-1:0] clock_out;
  logic [CH-1:0] tick_out;

  int checks = 0;
  int errors = 0;

  clock_divider_multi #(
    .CHANNELS(CH), .CNT_W(W), .DEFAULT_DIV(15), .DEFAULT_HIGH(1)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .pending  (pending),
    .clock_out(clock_out),
    .tick_out (tick_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct packed {
    logic [CH-1:0] clk;
    logic [CH-1:0] tick;
    logic [CH-1:0] pend;
  } exp_t;

  exp_t sb[$];

  // Reference model state, in the terms of the behavioural description.
  int m_cnt[CH], m_diva[CH], m_higha[CH], m_divs[CH], m_highs[CH];
  bit m_pend[CH], m_clk[CH], m_tick[CH];

  function automatic int clamp(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs now applied, and
  // queue the outputs the DUT must show after that edge.
  task automatic model_edge();
    bit   ready;
    bit   wrap;
    bit   apply;
    exp_t e;
    ready = !m_pend[cfg_chan];
    for (int i = 0; i < CH; i++) begin
      if (reset) begin
        m_cnt[i] = 0; m_diva[i] = 15; m_divs[i] = 15;
        m_higha[i] = 1; m_highs[i] = 1;
        m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end else begin
        wrap  = (m_cnt[i] == m_diva[i] - 1);
        apply = m_pend[i] && (!enable[i] || wrap);
        if (enable[i]) begin
          m_clk[i]  = (m_cnt[i] < m_higha[i]);
          m_tick[i] = (m_cnt[i] == 0);
          m_cnt[i]  = wrap ? 0 : m_cnt[i] + 1;
        end else begin
          m_clk[i] = 0; m_tick[i] = 0; m_cnt[i] = 0;
        end
        if (apply) begin
          m_diva[i] = m_divs[i]; m_higha[i] = m_highs[i]; m_pend[i] = 0;
        end
        if (cfg_valid && ready && int'(cfg_chan) == i) begin
          m_divs[i] = clamp(int'(cfg_div)); m_highs[i] = int'(cfg_high); m_pend[i] = 1;
        end
      end
    end
    for (int i = 0; i < CH; i++) begin
      e.clk[i]  = m_clk[i];
      e.pend[i] = m_pend[i];
`ifdef CLKDIV_TICK_EN
      e.tick[i] = m_tick[i];
`else
      e.tick[i] = 1'b0;
`endif
    end
    sb.push_back(e);
  endtask

  // One clock: check the handshake, predict, clock, then compare.
  task automatic cycle();
    exp_t e;
    if (!reset) check("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_chan]));
    model_edge();
    @(posedge clock_in);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      check("clock_out", 32'(clock_out), 32'(e.clk));
      check("tick_out",  32'(tick_out),  32'(e.tick));
      check("pending",   32'(pending),   32'(e.pend));
    end
  endtask

  task automatic write_cfg(input int ch, input int div, input int high);
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_div   = W'(div);
    cfg_high  = W'(high);
    cycle();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] p15;
    logic [11:0] p12;
    logic [9:0]  p10;
    logic [7:0]  p8;

    reset = 1'b1; enable = '0; cfg_valid = 1'b0; cfg_chan = '0;
    cfg_div = '0; cfg_high = '0;
    p15 = '0; p12 = '0; p10 = '0; p8 = '0;

    // Reset state
    cycle(); cycle();
    check("rst_clock_out", 32'(clock_out), 32'd0);
    check("rst_pending",   32'(pending),   32'd0);
    reset = 1'b0;

    // Defaults on ch0: one high cycle in fifteen
    enable = 4'b0001;
    for (int k = 0; k < 15; k++) begin
      cycle(); p15 = {p15[13:0], clock_out[0]};
    end
    check("ch0_default_pattern", 32'(p15), 32'(15'b100000000000000));

    // ch1 written while disabled: applies after one cycle
    write_cfg(1, 4, 2);
    check("ch1_pending_set", 32'(pending[1]), 32'd1);
    cycle();
    check("ch1_pending_clr", 32'(pending[1]), 32'd0);
    enable[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle(); p8 = {p8[6:0], clock_out[1]};
    end
    check("ch1_pattern_1100", 32'(p8), 32'(8'b11001100));

    // ch0 reprogrammed mid-period; current period must finish first
    write_cfg(0, 6, 3);
    for (int k = 0; k < 20 && pending[0]; k++) cycle();
    check("ch0_apply_bound", 32'(pending[0]), 32'd0);
    for (int k = 0; k < 12; k++) begin
      cycle(); p12 = {p12[10:0], clock_out[0]};
    end
    check("ch0_pattern_111000", 32'(p12), 32'(12'b111000111000));

    // Blocked write to pending ch2, accepted write to ch3
    enable[2] = 1'b1;
    write_cfg(2, 3, 1);
    cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_div = W'(7); cfg_high = W'(7);
    #1;
    check("ch2_ready_blocked", 32'(cfg_ready), 32'd0);
    cycle();
    cfg_chan = 2'd3; cfg_div = W'(5); cfg_high = W'(9);
    #1;
    check("ch3_ready", 32'(cfg_ready), 32'd1);
    cycle();
    cfg_valid = 1'b0;
    enable[3] = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    for (int k = 0; k < 10; k++) begin
      cycle(); p10 = {p10[8:0], clock_out[3]};
    end
    check("ch3_high_ge_div", 32'(p10), 32'h3FF);

    // div=1 high=0 on ch1: stored as div 2, output stuck low
    write_cfg(1, 1, 0);
    for (int k = 0; k < 10 && pending[1]; k++) cycle();
    check("ch1_apply_bound", 32'(pending[1]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cycle(); p8 = {p8[6:0], clock_out[1]};
    end
    check("ch1_high0_low", 32'(p8), 32'd0);
    // Apply timing of this write depends on the clamped period
    write_cfg(1, 3, 1);
    for (int k = 0; k < 6; k++) cycle();

    // Enable drop mid-period and restart at phase 0
    enable[0] = 1'b0;
    cycle();
    check("ch0_disabled_low", 32'(clock_out[0]), 32'd0);
    enable[0] = 1'b1;
    cycle();
    check("ch0_restart_high", 32'(clock_out[0]), 32'd1);
    for (int k = 0; k < 4; k++) cycle();

    // Reset while a write is pending drops it and restores defaults
    write_cfg(0, 10, 5);
    check("ch0_pending_before_rst", 32'(pending[0]), 32'd1);
    reset = 1'b1; enable = 4'b0001;
    cycle();
    check("rst_mid_clock_out", 32'(clock_out), 32'd0);
    check("rst_mid_tick_out",  32'(tick_out),  32'd0);
    check("rst_mid_pending",   32'(pending),   32'd0);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cycle(); p15 = {p15[13:0], clock_out[0]};
    end
    check("ch0_default_after_rst", 32'(p15), 32'(15'b100000000000000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
